// File: rtl/coralnpu_axi_pkg.sv
// Shared AXI4 encodings, master FSM states and the 4KB-boundary helper
// for the command master.
package coralnpu_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } mst_state_e;

  localparam int AXI_4KB = 4096;

  // Evaluated in int width, so the byte count past the page offset can never wrap.
  function automatic logic crosses_4kb(input logic [11:0] addr, input logic [7:0] len,
                                       input int bytes);
    int end_byte;
    end_byte = int'(addr) + (int'(len) + 1) * bytes;
    return end_byte > AXI_4KB;
  endfunction

endpackage

// File: rtl/coralnpu_axi_wbeat_ctr.sv
// W-channel beat counter: counts accepted beats from 0 up to the burst
// length and flags the final beat of the burst.
module coralnpu_axi_wbeat_ctr (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       beat,
  output logic       last,
  output logic       last_beat
);

  logic [7:0] count;
  logic [7:0] len_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 8'd0;
      len_q <= 8'd0;
    end else if (start) begin
      count <= 8'd0;
      len_q <= len;
    end else if (beat) begin
      count <= last ? 8'd0 : count + 8'd1;
    end
  end

  assign last      = (count == len_q);
  assign last_beat = beat && last;

endmodule

// File: rtl/coralnpu_axi_cmd_master.sv
// AXI4 master engine: turns a command + write-data stream into INCR bursts,
// guards 4KB crossings and limits outstanding bursts per direction.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | ready for a command (subject to outstanding limit)
//   ST_RD   | AR issued, waiting for arready
//   ST_WR   | AW and/or W burst still pending
module coralnpu_axi_cmd_master
  import coralnpu_axi_pkg::*;
#(
  parameter  int AWIDTH          = 32,
  parameter  int DWIDTH          = 128,
  parameter  int IDWIDTH         = 6,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1),
  localparam int BYTES           = DWIDTH / 8,
  localparam int SZ              = $clog2(BYTES)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [IDWIDTH-1:0] cmd_id,
  input  logic [AWIDTH-1:0]  cmd_addr,
  input  logic [7:0]         cmd_len,
  output logic               cmd_err,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DWIDTH-1:0]  wr_data,
  input  logic [BYTES-1:0]   wr_strb,
  output logic               awvalid,
  input  logic               awready,
  output logic [IDWIDTH-1:0] awid,
  output logic [AWIDTH-1:0]  awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awlock,
  output logic [3:0]         awcache,
  output logic [2:0]         awprot,
  output logic [3:0]         awqos,
  output logic [3:0]         awregion,
  output logic               wvalid,
  input  logic               wready,
  output logic [IDWIDTH-1:0] wid,
  output logic [DWIDTH-1:0]  wdata,
  output logic [BYTES-1:0]   wstrb,
  output logic               wlast,
  output logic               arvalid,
  input  logic               arready,
  output logic [IDWIDTH-1:0] arid,
  output logic [AWIDTH-1:0]  araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arlock,
  output logic [3:0]         arcache,
  output logic [2:0]         arprot,
  output logic [3:0]         arqos,
  output logic [3:0]         arregion,
  input  logic               bvalid,
  output logic               bready,
  input  logic [IDWIDTH-1:0] bid,
  input  logic [1:0]         bresp,
  input  logic               rvalid,
  output logic               rready,
  input  logic [IDWIDTH-1:0] rid,
  input  logic [DWIDTH-1:0]  rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [IDWIDTH-1:0] b_id,
  output logic [1:0]         b_resp,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [IDWIDTH-1:0] r_id,
  output logic [DWIDTH-1:0]  r_data,
  output logic [1:0]         r_resp,
  output logic               r_last,
  output logic [CW-1:0]      wr_outstanding,
  output logic [CW-1:0]      rd_outstanding,
  output logic               idle
);

  mst_state_e state, state_nxt;

  logic accept, bad, misaligned, go_wr, go_rd;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, w_last_hs;
  logic aw_done, w_done, w_open;
  logic wr_dec, rd_dec;

  assign cmd_ready = (state == ST_IDLE) &&
                     (cmd_write ? (wr_outstanding < CW'(MAX_OUTSTANDING))
                                : (rd_outstanding < CW'(MAX_OUTSTANDING)));
  assign accept     = cmd_valid && cmd_ready;
  assign misaligned = (cmd_addr & AWIDTH'(BYTES - 1)) != '0;
  assign bad        = misaligned || crosses_4kb(cmd_addr[11:0], cmd_len, BYTES);
  assign go_wr      = accept && !bad && cmd_write;
  assign go_rd      = accept && !bad && !cmd_write;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign b_hs  = bvalid && bready;
  assign r_hs  = rvalid && rready && rlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go_wr)      state_nxt = ST_WR;
        else if (go_rd) state_nxt = ST_RD;
      end
      ST_RD:   if (ar_hs) state_nxt = ST_IDLE;
      ST_WR:   if ((aw_done || aw_hs) && (w_done || w_last_hs)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_err <= 1'b0;
      awvalid <= 1'b0;
      awid    <= '0;
      awaddr  <= '0;
      awlen   <= 8'd0;
      wid     <= '0;
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= 8'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      cmd_err <= accept && bad;
      if (go_wr) begin
        awvalid <= 1'b1;
        awid    <= cmd_id;
        awaddr  <= cmd_addr;
        awlen   <= cmd_len;
        wid     <= cmd_id;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) begin
          awvalid <= 1'b0;
          aw_done <= 1'b1;
        end
        if (w_last_hs) w_done <= 1'b1;
      end
      if (go_rd) begin
        arvalid <= 1'b1;
        arid    <= cmd_id;
        araddr  <= cmd_addr;
        arlen   <= cmd_len;
      end else if (ar_hs) begin
        arvalid <= 1'b0;
      end
    end
  end

  // W beats stream straight from the requester while the burst window is open.
  assign w_open   = (state == ST_WR) && !w_done;
  assign wvalid   = wr_valid && w_open;
  assign wr_ready = wready && w_open;
  assign wdata    = wr_data;
  assign wstrb    = wr_strb;

  coralnpu_axi_wbeat_ctr u_wbeat_ctr (
    .clk       (clk),
    .resetn    (resetn),
    .start     (go_wr),
    .len       (cmd_len),
    .beat      (w_hs),
    .last      (wlast),
    .last_beat (w_last_hs)
  );

  assign wr_dec = b_hs && (wr_outstanding != '0);
  assign rd_dec = r_hs && (rd_outstanding != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_outstanding <= '0;
      rd_outstanding <= '0;
    end else begin
      case ({aw_hs, wr_dec})
        2'b10:   wr_outstanding <= wr_outstanding + CW'(1);
        2'b01:   wr_outstanding <= wr_outstanding - CW'(1);
        default: wr_outstanding <= wr_outstanding;
      endcase
      case ({ar_hs, rd_dec})
        2'b10:   rd_outstanding <= rd_outstanding + CW'(1);
        2'b01:   rd_outstanding <= rd_outstanding - CW'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  no_b_underflow: assert property (@(posedge clk) disable iff (!resetn)
                                   !(b_hs && wr_outstanding == '0));
  no_r_underflow: assert property (@(posedge clk) disable iff (!resetn)
                                   !(r_hs && rd_outstanding == '0));

  assign awsize   = 3'(SZ);
  assign awburst  = BURST_INCR;
  assign awlock   = 1'b0;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign awqos    = 4'd0;
  assign awregion = 4'd0;
  assign arsize   = 3'(SZ);
  assign arburst  = BURST_INCR;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arqos    = 4'd0;
  assign arregion = 4'd0;

  assign bready  = b_ready;
  assign b_valid = bvalid;
  assign b_id    = bid;
  assign b_resp  = bresp;
  assign rready  = r_ready;
  assign r_valid = rvalid;
  assign r_id    = rid;
  assign r_data  = rdata;
  assign r_resp  = rresp;
  assign r_last  = rlast;

  assign idle = (state == ST_IDLE) && (wr_outstanding == '0) && (rd_outstanding == '0);

endmodule

// File: tb/tb_coralnpu_axi_cmd_master.sv
// Scenario bench for coralnpu_axi_cmd_master: expected AR/AW/W/R/B items are
// queued when stimulus is driven and popped when the DUT presents them.
module tb_coralnpu_axi_cmd_master;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int IW  = 6;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);
  localparam int BY  = DW / 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cmd_valid = 0, cmd_write = 0, cmd_ready, cmd_err;
  logic [IW-1:0] cmd_id = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic wr_valid = 0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic [BY-1:0] wr_strb = '0;
  logic awvalid, awready = 0, awlock, arvalid, arready = 0, arlock;
  logic [IW-1:0] awid, arid, wid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic wvalid, wready = 0, wlast;
  logic [DW-1:0] wdata;
  logic [BY-1:0] wstrb;
  logic bvalid = 0, bready;
  logic [IW-1:0] bid = '0;
  logic [1:0] bresp = '0;
  logic rvalid = 0, rready, rlast = 0;
  logic [IW-1:0] rid = '0;
  logic [DW-1:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic b_valid, b_ready = 1, r_valid, r_ready = 1, r_last;
  logic [IW-1:0] b_id, r_id;
  logic [1:0] b_resp, r_resp;
  logic [DW-1:0] r_data;
  logic [CW-1:0] wr_outstanding, rd_outstanding;
  logic idle;

  always #5 clk = ~clk;

  coralnpu_axi_cmd_master #(.AWIDTH(AW), .DWIDTH(DW), .IDWIDTH(IW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awqos(awqos), .awregion(awregion),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arqos(arqos), .arregion(arregion),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding), .idle(idle)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; logic [IW-1:0] id; } a_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic [BY-1:0] strb; logic last; } w_exp_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;

  a_exp_t ar_q[$], aw_q[$];
  w_exp_t w_q[$];
  r_exp_t r_q[$];
  b_exp_t b_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] wpat(input int beat, input logic [IW-1:0] id);
    return {4{32'hA500_0000 | (32'(id) << 8) | 32'(beat)}};
  endfunction

  function automatic logic [BY-1:0] spat(input int beat);
    return BY'(16'h0F0F) << (beat % 4);
  endfunction

  // Called on a negedge; returns on the negedge after acceptance (or after budget).
  task automatic send_cmd(input logic w, input logic [IW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] l, input int budget, output bit ok);
    ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_id = id; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (cmd_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 0;
  endtask

  task automatic drive_write(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] l,
                             input int aw_delay, input int b_at, input bit chk_ready,
                             input logic [CW-1:0] exp_wr);
    bit ok;
    int beat = 0;
    int cyc = 0;
    bit aw_seen = 0;
    a_exp_t ea;
    w_exp_t ew;
    awready = 0; wready = 1;
    aw_q.push_back('{addr: a, len: l, id: id});
    for (int j = 0; j <= int'(l); j++)
      w_q.push_back('{data: wpat(j, id), strb: spat(j), last: (j == int'(l))});
    send_cmd(1'b1, id, a, l, 8, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wr_accept: got cmd_ready=0 expected accept"); end
    while ((beat <= int'(l) || !aw_seen) && cyc < 40) begin
      awready = (cyc >= aw_delay);
      bvalid = (cyc == b_at); bid = id; bresp = 2'b00;
      wr_valid = (beat <= int'(l));
      wr_data = wpat(beat, id); wr_strb = spat(beat);
      #1;
      if (chk_ready && !aw_seen) begin
        vectors++;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL wr_cmd_ready_low: got %b expected 0 (cyc %0d)", cmd_ready, cyc); end
      end
      if (wr_valid && wr_ready) begin
        ew = w_q.pop_front();
        vectors++;
        if (wvalid !== 1'b1 || {wdata, wstrb, wlast} !== {ew.data, ew.strb, ew.last} || wid !== id) begin
          miscompares++;
          $display("FAIL w_beat%0d: got data=%h strb=%h last=%b wid=%h expected data=%h strb=%h last=%b wid=%h",
                   beat, wdata, wstrb, wlast, wid, ew.data, ew.strb, ew.last, id);
        end
        beat++;
      end
      if (awvalid && awready) begin
        ea = aw_q.pop_front();
        vectors++;
        if ({awaddr, awlen, awid, awsize, awburst} !== {ea.addr, ea.len, ea.id, 3'd4, 2'b01}) begin
          miscompares++;
          $display("FAIL aw_beat: got addr=%h len=%0d id=%h size=%0d burst=%b expected addr=%h len=%0d id=%h size=4 burst=01",
                   awaddr, awlen, awid, awsize, awburst, ea.addr, ea.len, ea.id);
        end
        aw_seen = 1;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 0; awready = 0; bvalid = 0;
    vectors++;
    if (cyc >= 40) begin miscompares++; $display("FAIL wr_timeout: got beats=%0d aw=%0b expected burst complete", beat, aw_seen); end
    #1;
    vectors++;
    if (wr_outstanding !== exp_wr) begin miscompares++; $display("FAIL wr_outstanding_after_aw: got %0d expected %0d", wr_outstanding, exp_wr); end
    @(negedge clk);
  endtask

  task automatic return_b(input logic [IW-1:0] id, input logic [1:0] resp, input logic [CW-1:0] exp_after);
    b_exp_t eb;
    bvalid = 1; bid = id; bresp = resp;
    b_q.push_back('{id: id, resp: resp});
    #1;
    eb = b_q.pop_front();
    vectors++;
    if (b_valid !== 1'b1 || bready !== 1'b1 || {b_id, b_resp} !== {eb.id, eb.resp}) begin
      miscompares++;
      $display("FAIL b_fwd: got valid=%b id=%h resp=%b expected valid=1 id=%h resp=%b", b_valid, b_id, b_resp, eb.id, eb.resp);
    end
    @(negedge clk);
    bvalid = 0;
    #1;
    vectors++;
    if (wr_outstanding !== exp_after) begin miscompares++; $display("FAIL wr_outstanding_after_b: got %0d expected %0d", wr_outstanding, exp_after); end
    @(negedge clk);
  endtask

  task automatic return_r(input logic [IW-1:0] id, input int n, input logic [CW-1:0] exp_after);
    r_exp_t er;
    for (int i = 0; i < n; i++) begin
      rvalid = 1; rid = id; rdata = {$urandom, $urandom, $urandom, $urandom};
      rresp = (i == 1) ? 2'b10 : 2'b00; rlast = (i == n - 1);
      r_q.push_back('{id: id, data: rdata, resp: rresp, last: rlast});
      #1;
      er = r_q.pop_front();
      vectors++;
      if (r_valid !== 1'b1 || rready !== 1'b1 || {r_id, r_data, r_resp, r_last} !== {er.id, er.data, er.resp, er.last}) begin
        miscompares++;
        $display("FAIL r_fwd%0d: got id=%h data=%h resp=%b last=%b expected id=%h data=%h resp=%b last=%b",
                 i, r_id, r_data, r_resp, r_last, er.id, er.data, er.resp, er.last);
      end
      vectors++;
      if (32'(rd_outstanding) !== 32'(exp_after) + 1) begin
        miscompares++; $display("FAIL rd_outstanding_pending: got %0d expected %0d", rd_outstanding, 32'(exp_after) + 1);
      end
      @(negedge clk);
    end
    rvalid = 0; rlast = 0;
    #1;
    vectors++;
    if (rd_outstanding !== exp_after) begin miscompares++; $display("FAIL rd_outstanding_after_rlast: got %0d expected %0d", rd_outstanding, exp_after); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 0; wr_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({awvalid, arvalid, wvalid, wr_ready, cmd_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_valids: got aw=%b ar=%b w=%b wr_ready=%b err=%b expected all 0", awvalid, arvalid, wvalid, wr_ready, cmd_err);
    end
    vectors++;
    if (wr_outstanding !== 0 || rd_outstanding !== 0 || idle !== 1'b1 || awaddr !== 0 || araddr !== 0) begin
      miscompares++; $display("FAIL reset_state: got wr=%0d rd=%0d idle=%b awaddr=%h araddr=%h expected 0 0 1 0 0", wr_outstanding, rd_outstanding, idle, awaddr, araddr);
    end
    @(negedge clk);
    resetn = 1; wr_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_read();
    bit ok;
    a_exp_t ea;
    arready = 1;
    ar_q.push_back('{addr: 32'h100, len: 8'd3, id: 6'h05});
    send_cmd(1'b0, 6'h05, 32'h100, 8'd3, 4, ok);
    #1;
    vectors++;
    if (!ok || arvalid !== 1'b1) begin
      miscompares++; $display("FAIL rd_ar_valid: got ok=%b arvalid=%b expected 1 1", ok, arvalid);
    end else begin
      ea = ar_q.pop_front();
      vectors++;
      if ({araddr, arlen, arid, arsize, arburst, arcache, arprot} !== {ea.addr, ea.len, ea.id, 3'd4, 2'b01, 4'd0, 3'd0}) begin
        miscompares++; $display("FAIL rd_ar_fields: got addr=%h len=%0d id=%h size=%0d burst=%b expected addr=%h len=%0d id=%h size=4 burst=01",
                                araddr, arlen, arid, arsize, arburst, ea.addr, ea.len, ea.id);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (arvalid !== 1'b0 || rd_outstanding !== 1 || idle !== 1'b0) begin
      miscompares++; $display("FAIL rd_after_ar: got arvalid=%b rd=%0d idle=%b expected 0 1 0", arvalid, rd_outstanding, idle);
    end
    @(negedge clk);
    return_r(6'h05, 4, 0);
    vectors++;
    if (idle !== 1'b1) begin miscompares++; $display("FAIL rd_idle: got %b expected 1", idle); end
  endtask

  task automatic test_write();
    drive_write(6'h21, 32'h200, 8'd1, 3, -1, 1, 1);
    return_b(6'h21, 2'b10, 0);
  endtask

  task automatic test_guard();
    bit ok;
    wr_valid = 1; wr_data = wpat(0, 0);
    send_cmd(1'b1, 6'h01, 32'hFF0, 8'd1, 4, ok);
    #1;
    vectors++;
    if (!ok || cmd_err !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
      miscompares++; $display("FAIL guard_4kb: got ok=%b err=%b awvalid=%b wvalid=%b expected 1 1 0 0", ok, cmd_err, awvalid, wvalid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (cmd_err !== 1'b0 || awvalid !== 1'b0 || idle !== 1'b1) begin
      miscompares++; $display("FAIL guard_pulse: got err=%b awvalid=%b idle=%b expected 0 0 1", cmd_err, awvalid, idle);
    end
    @(negedge clk);
    wr_valid = 0;
    send_cmd(1'b0, 6'h02, 32'h108, 8'd0, 4, ok);
    #1;
    vectors++;
    if (cmd_err !== 1'b1 || arvalid !== 1'b0) begin
      miscompares++; $display("FAIL guard_misaligned: got err=%b arvalid=%b expected 1 0", cmd_err, arvalid);
    end
    @(negedge clk);
    drive_write(6'h03, 32'hFE0, 8'd1, 0, -1, 0, 1);
    return_b(6'h03, 2'b00, 0);
  endtask

  task automatic test_limit();
    bit ok;
    a_exp_t ea;
    logic [AW-1:0] a;
    arready = 1;
    for (int k = 0; k < 5; k++) begin
      a = 32'h2000 + 32'(k * 64);
      if (k == 4) begin
        send_cmd(1'b0, IW'(k), a, 8'd0, 4, ok);
        vectors++;
        if (ok) begin miscompares++; $display("FAIL limit_5th_blocked: got accepted expected cmd_ready=0 (rd=%0d)", rd_outstanding); end
        #1;
        vectors++;
        if (rd_outstanding !== 4 || arvalid !== 1'b0) begin
          miscompares++; $display("FAIL limit_count: got rd=%0d arvalid=%b expected 4 0", rd_outstanding, arvalid);
        end
        @(negedge clk);
        return_r(6'h00, 1, 3);
      end
      ar_q.push_back('{addr: a, len: 8'd0, id: IW'(k)});
      send_cmd(1'b0, IW'(k), a, 8'd0, 4, ok);
      #1;
      vectors++;
      if (!ok || arvalid !== 1'b1) begin
        miscompares++; $display("FAIL limit_ar%0d: got ok=%b arvalid=%b expected 1 1", k, ok, arvalid);
      end else begin
        ea = ar_q.pop_front();
        vectors++;
        if ({araddr, arid} !== {ea.addr, ea.id}) begin
          miscompares++; $display("FAIL limit_ar%0d_fields: got addr=%h id=%h expected addr=%h id=%h", k, araddr, arid, ea.addr, ea.id);
        end
      end
      @(negedge clk);
    end
    for (int k = 1; k <= 4; k++) return_r(IW'(k), 1, CW'(4 - k));
  endtask

  task automatic test_back_to_back();
    drive_write(6'h10, 32'h3000, 8'd0, 0, -1, 0, 1);
    drive_write(6'h11, 32'h3100, 8'd2, 0, -1, 0, 2);
    drive_write(6'h12, 32'h3200, 8'd0, 1, 1, 0, 2);
    return_b(6'h11, 2'b00, 1);
    return_b(6'h12, 2'b00, 0);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    awready = 1; wready = 1;
    send_cmd(1'b1, 6'h07, 32'h400, 8'd7, 4, ok);
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1; wr_data = wpat(b, 6'h07); wr_strb = spat(b);
      @(negedge clk);
    end
    wr_valid = 1; wr_data = wpat(2, 6'h07);
    #1;
    vectors++;
    if (!ok || wvalid !== 1'b1 || wr_outstanding !== 1) begin
      miscompares++; $display("FAIL mid_burst_pre: got ok=%b wvalid=%b wr=%0d expected 1 1 1", ok, wvalid, wr_outstanding);
    end
    #1;
    resetn = 0;
    #1;
    vectors++;
    if ({awvalid, wvalid, arvalid, wr_ready} !== 4'b0 || wr_outstanding !== 0) begin
      miscompares++; $display("FAIL mid_burst_reset: got aw=%b w=%b ar=%b wr_ready=%b wr=%0d expected 0 0 0 0 0", awvalid, wvalid, arvalid, wr_ready, wr_outstanding);
    end
    @(negedge clk);
    resetn = 1; wr_valid = 0; awready = 0;
    w_q.delete(); aw_q.delete();
    #1;
    vectors++;
    if (idle !== 1'b1 || wr_outstanding !== 0 || rd_outstanding !== 0) begin
      miscompares++; $display("FAIL mid_burst_release: got idle=%b wr=%0d rd=%0d expected 1 0 0", idle, wr_outstanding, rd_outstanding);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_guard();
    test_limit();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
